// File: rtl/data_sram_arb_if.sv
// Bundle of the two requester ports (inst, data) and the single memory port
// arbitrated by data_sram_arb.
interface data_sram_arb_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata
  );

  // Environment side: requesters plus memory model.
  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_sram_arb.sv
// Two-requester (inst/data) arbiter onto one SRAM-like memory port, one
// transaction outstanding. Define ARB_RR_EN for round-robin; default is data-first.
module data_sram_arb (
  input  logic               clk,
  input  logic               reset,
  data_sram_arb_if.slave     bus,
  output logic [1:0]         state_dbg,
  output logic               grant_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  // Handshake: a requester holds *_req (and its wr/size/addr/wdata) until it
  // sees *_addr_ok; mem_req likewise holds until mem_addr_ok. *_data_ok and
  // mem_data_ok are single-cycle completion pulses with no back-pressure.

  logic [1:0] state;
  logic       grant;
  logic       winner;
  logic       any_req;
  logic       in_addr;
  logic       in_data;
  logic       addr_ok_pulse;
  logic       data_ok_pulse;

  assign any_req = bus.inst_req | bus.data_req;

`ifdef ARB_RR_EN
  logic last_grant;

  always_comb begin
    winner = bus.data_req ? GRANT_DATA : GRANT_INST;
    if (bus.inst_req && bus.data_req) winner = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_INST;
    end else if (state == IDLE && any_req) begin
      last_grant <= winner;
    end
  end
`else
  assign winner = bus.data_req ? GRANT_DATA : GRANT_INST;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= GRANT_DATA;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= winner;
            state <= ADDR;
          end
        end
        ADDR: begin
          // A coincident mem_data_ok here is ignored: only acceptance counts.
          if (bus.mem_addr_ok) state <= DATA;
        end
        DATA: begin
          if (bus.mem_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, independent of the state.
  assign in_addr       = (state == ADDR) && !reset;
  assign in_data       = (state == DATA) && !reset;
  assign addr_ok_pulse = in_addr & bus.mem_addr_ok;
  assign data_ok_pulse = in_data & bus.mem_data_ok;

  assign bus.mem_req   = in_addr;
  assign bus.mem_wr    = (grant == GRANT_DATA) ? bus.data_wr    : bus.inst_wr;
  assign bus.mem_size  = (grant == GRANT_DATA) ? bus.data_size  : bus.inst_size;
  assign bus.mem_addr  = (grant == GRANT_DATA) ? bus.data_addr  : bus.inst_addr;
  assign bus.mem_wdata = (grant == GRANT_DATA) ? bus.data_wdata : bus.inst_wdata;

  assign bus.data_addr_ok = addr_ok_pulse & (grant == GRANT_DATA);
  assign bus.inst_addr_ok = addr_ok_pulse & (grant == GRANT_INST);
  assign bus.data_data_ok = data_ok_pulse & (grant == GRANT_DATA);
  assign bus.inst_data_ok = data_ok_pulse & (grant == GRANT_INST);

  assign bus.inst_rdata = bus.mem_rdata;
  assign bus.data_rdata = bus.mem_rdata;

  assign state_dbg = state;
  assign grant_dbg = grant;

endmodule

// File: tb/tb_data_sram_arb.sv
// Directed self-checking bench for data_sram_arb; scenario tasks run in
// sequence and compare DUT outputs against hand-computed values.
module tb_data_sram_arb;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  logic       grant_dbg;
  int         errors;
  int         checks;

  data_sram_arb_if bus ();

  data_sram_arb dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg),
    .grant_dbg (grant_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs are changed 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 0; bus.inst_addr = 0; bus.inst_wdata = 0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_addr = 0; bus.data_wdata = 0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    cyc(); cyc(); #1;
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    checks++; if (grant_dbg !== 1'b1) begin errors++; $display("FAIL reset_grant got=%0b exp=1", grant_dbg); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0b exp=0", bus.mem_req); end
    checks++;
    if ({bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok} !== 4'b0) begin
      errors++; $display("FAIL reset_oks got=%b exp=0000", {bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok});
    end
    reset = 0;
    // Stray mem_data_ok in IDLE must not produce a pulse or a state change.
    cyc(); bus.mem_data_ok = 1; bus.mem_rdata = 32'hAAAA5555; #1;
    checks++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin errors++; $display("FAIL idle_stray_data_ok got=%b exp=00", {bus.inst_data_ok, bus.data_data_ok}); end
    checks++; if (bus.data_rdata !== 32'hAAAA5555) begin errors++; $display("FAIL rdata_passthru got=%h exp=aaaa5555", bus.data_rdata); end
    cyc(); bus.mem_data_ok = 0; #1;
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL idle_stray_state got=%0d exp=%0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_single_read();
    cyc(); bus.data_req = 1; bus.data_wr = 0; bus.data_size = 2; bus.data_addr = 32'h1000; #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL read_T_mem_req got=%0b exp=0", bus.mem_req); end
    cyc(); bus.mem_addr_ok = 1; #1;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL read_T1_mem_req got=%0b exp=1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h1000) begin errors++; $display("FAIL read_mem_addr got=%h exp=00001000", bus.mem_addr); end
    checks++; if (bus.data_addr_ok !== 1'b1 || bus.inst_addr_ok !== 1'b0) begin errors++; $display("FAIL read_addr_ok got=d%0b/i%0b exp=d1/i0", bus.data_addr_ok, bus.inst_addr_ok); end
    cyc(); bus.data_req = 0; bus.mem_addr_ok = 0; bus.mem_data_ok = 1; bus.mem_rdata = 32'hDEADBEEF; #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL read_T2_mem_req got=%0b exp=0", bus.mem_req); end
    checks++; if (bus.data_data_ok !== 1'b1 || bus.inst_data_ok !== 1'b0) begin errors++; $display("FAIL read_data_ok got=d%0b/i%0b exp=d1/i0", bus.data_data_ok, bus.inst_data_ok); end
    checks++; if (bus.data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata got=%h exp=deadbeef", bus.data_rdata); end
    checks++; if (bus.data_addr_ok !== 1'b0) begin errors++; $display("FAIL read_addr_ok_in_data got=%0b exp=0", bus.data_addr_ok); end
    cyc(); bus.mem_data_ok = 0; #1;
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL read_return_idle got=%0d exp=%0d", state_dbg, S_IDLE); end
  endtask

`ifndef ARB_RR_EN
  task automatic test_fixed_priority();
    cyc(); bus.inst_req = 1; bus.inst_addr = 32'h200; bus.data_req = 1; bus.data_addr = 32'h100; #1;
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.mem_addr_ok = 1; #1;
      checks++; if (bus.mem_addr !== 32'h100 + 32'(i * 4)) begin errors++; $display("FAIL fixed_addr[%0d] got=%h exp=%h", i, bus.mem_addr, 32'h100 + 32'(i * 4)); end
      checks++; if (bus.data_addr_ok !== 1'b1 || bus.inst_addr_ok !== 1'b0) begin errors++; $display("FAIL fixed_addr_ok[%0d] got=d%0b/i%0b exp=d1/i0", i, bus.data_addr_ok, bus.inst_addr_ok); end
      cyc(); bus.mem_addr_ok = 0; bus.mem_data_ok = 1; bus.data_addr = 32'h100 + 32'((i + 1) * 4); #1;
      checks++; if (bus.data_data_ok !== 1'b1 || bus.inst_data_ok !== 1'b0) begin errors++; $display("FAIL fixed_data_ok[%0d] got=d%0b/i%0b exp=d1/i0", i, bus.data_data_ok, bus.inst_data_ok); end
      cyc(); bus.mem_data_ok = 0; #1;
      checks++; if (bus.mem_req !== 1'b0 || state_dbg !== S_IDLE) begin errors++; $display("FAIL fixed_idle_gap[%0d] got=req%0b/st%0d exp=req0/st0", i, bus.mem_req, state_dbg); end
    end
    bus.data_req = 0;
    cyc(); bus.mem_addr_ok = 1; #1;
    checks++; if (bus.inst_addr_ok !== 1'b1 || bus.mem_addr !== 32'h200) begin errors++; $display("FAIL fixed_inst_after got=ok%0b/%h exp=ok1/00000200", bus.inst_addr_ok, bus.mem_addr); end
    cyc(); bus.inst_req = 0; bus.mem_addr_ok = 0; bus.mem_data_ok = 1; #1;
    checks++; if (bus.inst_data_ok !== 1'b1) begin errors++; $display("FAIL fixed_inst_data_ok got=%0b exp=1", bus.inst_data_ok); end
    cyc(); bus.mem_data_ok = 0;
  endtask
`else
  task automatic test_round_robin();
    logic exp_g;
    reset = 1; cyc(); reset = 0;
    bus.inst_req = 1; bus.inst_addr = 32'h200; bus.data_req = 1; bus.data_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0);
      cyc(); bus.mem_addr_ok = 1; #1;
      checks++; if (grant_dbg !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%0b exp=%0b", i, grant_dbg, exp_g); end
      checks++; if (bus.data_addr_ok !== exp_g || bus.inst_addr_ok !== !exp_g) begin errors++; $display("FAIL rr_addr_ok[%0d] got=d%0b/i%0b exp_data=%0b", i, bus.data_addr_ok, bus.inst_addr_ok, exp_g); end
      cyc(); bus.mem_addr_ok = 0; bus.mem_data_ok = 1; #1;
      checks++; if (bus.data_data_ok !== exp_g || bus.inst_data_ok !== !exp_g) begin errors++; $display("FAIL rr_data_ok[%0d] got=d%0b/i%0b exp_data=%0b", i, bus.data_data_ok, bus.inst_data_ok, exp_g); end
      cyc(); bus.mem_data_ok = 0;
    end
    bus.inst_req = 0; bus.data_req = 0;
    cyc();
  endtask
`endif

  task automatic test_wait_states();
    int n_addr_ok;
    int n_data_ok;
    n_addr_ok = 0; n_data_ok = 0;
    cyc(); bus.data_req = 1; bus.data_wr = 1; bus.data_size = 1; bus.data_addr = 32'h2000; bus.data_wdata = 32'hCAFEF00D; #1;
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.mem_data_ok = (i == 1); #1;
      n_addr_ok += int'(bus.data_addr_ok) + int'(bus.inst_addr_ok);
      n_data_ok += int'(bus.data_data_ok) + int'(bus.inst_data_ok);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h2000 || bus.mem_wr !== 1'b1 || bus.mem_wdata !== 32'hCAFEF00D || bus.mem_size !== 2'd1) begin
        errors++; $display("FAIL wait_addr_stable[%0d] got=req%0b %h wr%0b %h sz%0d exp=req1 00002000 wr1 cafef00d sz1", i, bus.mem_req, bus.mem_addr, bus.mem_wr, bus.mem_wdata, bus.mem_size);
      end
    end
    // Acceptance and a coincident data_ok: only the acceptance may be seen.
    cyc(); bus.mem_addr_ok = 1; bus.mem_data_ok = 1; #1;
    n_addr_ok += int'(bus.data_addr_ok) + int'(bus.inst_addr_ok);
    n_data_ok += int'(bus.data_data_ok) + int'(bus.inst_data_ok);
    checks++; if (bus.data_addr_ok !== 1'b1) begin errors++; $display("FAIL wait_addr_ok got=%0b exp=1", bus.data_addr_ok); end
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.data_req = 0; bus.mem_addr_ok = 0; bus.mem_data_ok = (i == 2); #1;
      n_addr_ok += int'(bus.data_addr_ok) + int'(bus.inst_addr_ok);
      n_data_ok += int'(bus.data_data_ok) + int'(bus.inst_data_ok);
      checks++; if (bus.data_data_ok !== (i == 2)) begin errors++; $display("FAIL wait_data_ok[%0d] got=%0b exp=%0b", i, bus.data_data_ok, (i == 2)); end
    end
    cyc(); bus.mem_data_ok = 0; #1;
    checks++; if (n_addr_ok !== 1) begin errors++; $display("FAIL wait_addr_ok_count got=%0d exp=1", n_addr_ok); end
    checks++; if (n_data_ok !== 1) begin errors++; $display("FAIL wait_data_ok_count got=%0d exp=1", n_data_ok); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL wait_end_state got=%0d exp=%0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_reset_in_data();
    cyc(); bus.inst_req = 1; bus.inst_wr = 0; bus.inst_addr = 32'h4000; #1;
    cyc(); bus.mem_addr_ok = 1; #1;
    cyc(); bus.inst_req = 0; bus.mem_addr_ok = 0; reset = 1; #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.inst_data_ok !== 1'b0) begin errors++; $display("FAIL rst_data_outputs got=req%0b/dok%0b exp=0/0", bus.mem_req, bus.inst_data_ok); end
    cyc(); reset = 0; bus.mem_data_ok = 1; #1;
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rst_data_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    checks++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin errors++; $display("FAIL rst_data_stray got=%b exp=00", {bus.inst_data_ok, bus.data_data_ok}); end
    cyc(); bus.mem_data_ok = 0; #1;
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rst_data_stay_idle got=%0d exp=%0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_write();
    cyc(); bus.inst_req = 1; bus.inst_wr = 1; bus.inst_size = 2; bus.inst_addr = 32'h3000; bus.inst_wdata = 32'h12345678; #1;
    cyc(); bus.mem_addr_ok = 1; #1;
    checks++; if (bus.mem_wdata !== 32'h12345678 || bus.mem_wr !== 1'b1 || bus.mem_size !== 2'd2) begin errors++; $display("FAIL write_mem got=%h wr%0b sz%0d exp=12345678 wr1 sz2", bus.mem_wdata, bus.mem_wr, bus.mem_size); end
    checks++; if (bus.inst_addr_ok !== 1'b1 || bus.data_addr_ok !== 1'b0) begin errors++; $display("FAIL write_addr_ok got=i%0b/d%0b exp=i1/d0", bus.inst_addr_ok, bus.data_addr_ok); end
    cyc(); bus.inst_req = 0; bus.mem_addr_ok = 0; #1;
    checks++; if (bus.inst_data_ok !== 1'b0) begin errors++; $display("FAIL write_early_data_ok got=%0b exp=0", bus.inst_data_ok); end
    cyc(); bus.mem_data_ok = 1; #1;
    checks++; if (bus.inst_data_ok !== 1'b1 || bus.data_data_ok !== 1'b0) begin errors++; $display("FAIL write_data_ok got=i%0b/d%0b exp=i1/d0", bus.inst_data_ok, bus.data_data_ok); end
    cyc(); bus.mem_data_ok = 0; bus.inst_wr = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1;
    clear_inputs();
    test_reset();
    test_single_read();
`ifndef ARB_RR_EN
    test_fixed_priority();
`else
    test_round_robin();
`endif
    test_wait_states();
    test_reset_in_data();
    test_write();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
